// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one ALU between two requesters; result captured LATENCY cycles after accept.
// Illegal opcodes answer one cycle after accept; a held response stalls all new accepts until rsp_ready.
module alu_share_ctrl #(
  parameter int N       = 32,
  parameter int LATENCY = 2
) (
  input  logic         CLK,
  input  logic         Reset_L,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_ctrl,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_ctrl,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic [3:0]   ALUCtrl,
  output logic [N-1:0] BusA,
  output logic [N-1:0] BusB,
  input  logic [N-1:0] BusW,
  input  logic         Zero,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_data,
  output logic         rsp_zero,
  output logic         rsp_err,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LP_CNT_INIT = 4'(LATENCY - 1);

  state_t       r_state;
  state_t       w_next;
  logic [3:0]   r_cnt;
  logic         r_rr_last;
  logic [3:0]   r_alu_ctrl;
  logic [N-1:0] r_bus_a;
  logic [N-1:0] r_bus_b;
  logic         r_rsp_vld;
  logic         r_rsp_id;
  logic [N-1:0] r_rsp_data;
  logic         r_rsp_zero;
  logic         r_rsp_err;

  logic         w_idle;
  logic         w_sel;
  logic         w_accept;
  logic         w_illegal;
  logic [3:0]   w_ctrl;
  logic [N-1:0] w_a;
  logic [N-1:0] w_b;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    w_idle     = (r_state == IDLE);
    w_sel      = (req0_valid && req1_valid) ? ~r_rr_last : req1_valid;
    w_accept   = w_idle && (req0_valid || req1_valid);
    req0_ready = w_idle && req0_valid && !w_sel;
    req1_ready = w_idle && w_sel;
    w_ctrl     = w_sel ? req1_ctrl : req0_ctrl;
    w_a        = w_sel ? req1_a    : req0_a;
    w_b        = w_sel ? req1_b    : req0_b;
    w_illegal  = (w_ctrl == 4'b0101) || (w_ctrl == 4'b1111);
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = w_illegal ? RESP : EXEC;
      EXEC: if (r_cnt == 4'd0) w_next = RESP;
      RESP: if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_cnt      <= 4'd0;
      r_rr_last  <= 1'b1;
      r_alu_ctrl <= 4'd0;
      r_bus_a    <= '0;
      r_bus_b    <= '0;
      r_rsp_vld  <= 1'b0;
      r_rsp_id   <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_alu_ctrl <= w_ctrl;
            r_bus_a    <= w_a;
            r_bus_b    <= w_b;
            r_rsp_id   <= w_sel;
            r_rr_last  <= w_sel;
            r_cnt      <= LP_CNT_INIT;
            if (w_illegal) begin
              r_rsp_data <= '0;
              r_rsp_zero <= 1'b0;
              r_rsp_err  <= 1'b1;
              r_rsp_vld  <= 1'b1;
            end
          end
        end
        EXEC: begin
          // BusW/Zero are only trusted on this single capture edge.
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rsp_data <= BusW;
            r_rsp_zero <= Zero;
            r_rsp_err  <= 1'b0;
            r_rsp_vld  <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) r_rsp_vld <= 1'b0;
        end
        default: r_rsp_vld <= 1'b0;
      endcase
    end
  end

  assign ALUCtrl   = r_alu_ctrl;
  assign BusA      = r_bus_a;
  assign BusB      = r_bus_b;
  assign rsp_valid = r_rsp_vld;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_zero  = r_rsp_zero;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != IDLE);

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencer/arbiter that shares one 32-bit ALU (4-bit ALUCtrl, BusA/BusB in, BusW/Zero out) between two requesters.
- Accepts one operation at a time via valid/ready, round-robin arbitration, drives registered operands/control to the ALU, waits a fixed settle latency, captures BusW/Zero, returns them with requester ID via valid/ready response port.
- Sits between the datapath's issue logic and the shared ALU instance.

Parameters:
- N, 32, datapath width of operands and result.
- LATENCY, 2, clock cycles from operand launch to BusW/Zero capture; legal range 1..15.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset_L  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
- req0_ctrl  input  4  requester 0 ALU opcode.
- req0_a  input  N  requester 0 operand A.
- req0_b  input  N  requester 0 operand B.
- req1_valid, req1_ready, req1_ctrl, req1_a, req1_b: same as above, requester 1.
- ALUCtrl  output  4  opcode to ALU.
- BusA  output  N  operand A to ALU.
- BusB  output  N  operand B to ALU.
- BusW  input  N  ALU result.
- Zero  input  1  ALU zero flag.
- rsp_valid  output  1  response held valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  1  requester that issued this response.
- rsp_data  output  N  captured result.
- rsp_zero  output  1  captured Zero flag.
- rsp_err  output  1  opcode was illegal.
- busy  output  1  state != IDLE.

Behaviour:
- Async reset (Reset_L low): state=IDLE; ALUCtrl, BusA, BusB, rsp_data, rsp_id, rsp_zero, rsp_err, rsp_valid, busy = 0; counter=0; rr_last=1 (requester 0 wins first tie).
- States: IDLE, EXEC, RESP.
- IDLE arbitration (combinational): only one valid -> that one selected; both valid -> requester != rr_last. reqX_ready = (state==IDLE) && selected==X; never both high; both low outside IDLE.
- IDLE accept edge (valid&&ready): latch ctrl/a/b into ALUCtrl/BusA/BusB regs, rsp_id=X, rr_last=X.
  - Legal opcode: counter=LATENCY-1, -> EXEC.
  - Illegal opcode (4'b0101, 4'b1111): rsp_data=0, rsp_zero=0, rsp_err=1, -> RESP directly; ALU outputs ignored.
- EXEC: ALUCtrl/BusA/BusB stable. counter!=0 -> decrement. counter==0 -> rsp_data=BusW, rsp_zero=Zero, rsp_err=0, -> RESP.
- Latency: accept edge at T; capture at T+LATENCY; rsp_valid high from T+LATENCY.
- RESP: rsp_valid=1; rsp_* held stable until rsp_valid&&rsp_ready edge -> IDLE, rsp_valid=0. No acceptance in RESP; next accept earliest the cycle after response handshake. Min interval between accepts = LATENCY+2 cycles with rsp_ready tied high.
- ALU drive regs keep last operation's values in IDLE/RESP (no reset to 0 between ops).
- Requester changing ctrl/a/b while not accepted: no effect.
- Valid dropped before acceptance: legal, no side effects.
- Reset mid-EXEC/RESP: operation and pending response discarded; no rsp_valid after reset release until a new accept.
- Zero/BusW sampled only on the EXEC capture edge; glitches elsewhere ignored.

Test Plan:
- Reset, then req0 ADD(4'b0010) a=5 b=7, LATENCY=2, rsp_ready=1 -> req0_ready pulse 1 cycle, rsp_valid 2 cycles after accept, rsp_id=0, rsp_data=12, rsp_zero=0, rsp_err=0.
- Both valid from reset, req0 SUB 9-9, req1 OR 0xF0|0x0F -> req0 granted first (rsp_data=0, rsp_zero=1), then req1 (rsp_id=1, rsp_data=0xFF); both held valid again -> grants alternate 0,1,0,1.
- req1 opcode 4'b1111 -> rsp_valid next cycle after accept, rsp_err=1, rsp_data=0, ALU capture skipped.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, req*_ready=0 throughout; rsp_ready=1 -> IDLE next cycle, then accept.
- Reset_L low during EXEC of SLT -> all outputs 0 immediately; after release no response emitted, rr_last=1.
- LATENCY=1 build: AND 0xFFFF0000 & 0x00FFFF00 -> rsp_valid 1 cycle after accept, rsp_data=0x00FF0000.
